// File: rtl/phy_link_poller_pkg.sv
// gmac_poll_pkg: shared types, speed encodings and MAC config word helper
// for the PHY link poller.
package gmac_poll_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PHY_REQ,
        PHY_WAIT,
        DECODE,
        MAC_RD_REQ,
        MAC_RD_WAIT,
        MAC_WR_REQ,
        MAC_WR_WAIT
    } state_e;

    localparam logic [1:0] SPD_10   = 2'b00;
    localparam logic [1:0] SPD_100  = 2'b01;
    localparam logic [1:0] SPD_1000 = 2'b10;
    localparam logic [1:0] SPD_RSVD = 2'b11;

    function automatic logic [31:0] mac_cfg_word(
        input logic [31:0] rd,
        input logic [1:0]  spd,
        input logic        dpx,
        input logic [4:0]  ps_bit,
        input logic [4:0]  fes_bit,
        input logic [4:0]  dm_bit
    );
        logic [31:0] w;
        w          = rd;
        w[ps_bit]  = ~spd[1];
        w[fes_bit] = (spd == SPD_100);
        w[dm_bit]  = dpx;
        return w;
    endfunction

endpackage

// File: rtl/phy_link_poller_poll_timer.sv
// poll_timer: loadable down-counter that saturates at zero; counts only
// while enabled and flags zero.
module poll_timer #(
    parameter int           W       = 16,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? load_val_i : (en_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cnt_q <= RST_VAL;
        else          cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/phy_link_poller.sv
// phy_link_poller: polls a PHY status register over MDIO and rewrites the MAC
// speed/duplex config via read-modify-write whenever the negotiated mode changes.
module phy_link_poller
    import gmac_poll_pkg::*;
#(
    parameter logic [19:0] POLL_DIV     = 20'd125000,
    parameter logic [4:0]  PHY_ADDR     = 5'h00,
    parameter logic [4:0]  PHY_REG      = 5'h11,
    parameter int          SPD_LSB      = 14,
    parameter int          DPX_BIT      = 13,
    parameter int          LINK_BIT     = 10,
    parameter logic [13:0] MAC_CFG_ADDR = 14'h0000,
    parameter int          MAC_PS_BIT   = 15,
    parameter int          MAC_FES_BIT  = 14,
    parameter int          MAC_DM_BIT   = 11,
    parameter logic [15:0] TIMEOUT      = 16'd4096
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic        i_force_update,
    output logic [4:0]  o_phy_addr,
    output logic [4:0]  o_phy_reg,
    output logic [31:0] o_phy_wr_data,
    output logic        o_phy_rdwn,
    output logic        o_phy_request,
    input  logic        i_phy_done,
    input  logic [31:0] i_phy_rd_data,
    output logic [13:0] o_mac_addr,
    output logic [31:0] o_mac_wr_data,
    output logic        o_mac_rdwn,
    output logic        o_mac_request,
    input  logic        i_mac_done,
    input  logic [31:0] i_mac_rd_data,
    output logic        o_mux,
    output logic        o_link_up,
    output logic [1:0]  o_speed,
    output logic        o_duplex,
    output logic        o_update,
    output logic        o_timeout
);

    state_e      state_q, state_d;
    logic [1:0]  pspd_q, speed_q;
    logic        pdpx_q, plink_q, duplex_q, link_q, force_q;
    logic        phy_req_q, mac_req_q, mac_rdwn_q, mux_q, update_q, timeout_q;
    logic [31:0] wr_data_q;
    logic        poll_zero, tmo_zero, in_wait, done, tmo_fire, wr_done, skip, idle_en;
    logic        unused_phy_bits;

    assign unused_phy_bits = ^i_phy_rd_data;

    assign idle_en  = (state_q == IDLE) && i_enable;
    assign in_wait  = state_q inside {PHY_WAIT, MAC_RD_WAIT, MAC_WR_WAIT};
    assign done     = (state_q == PHY_WAIT) ? i_phy_done : i_mac_done;
    assign tmo_fire = in_wait && !done && tmo_zero;
    assign wr_done  = (state_q == MAC_WR_WAIT) && i_mac_done;
    assign skip     = !plink_q || pspd_q == SPD_RSVD ||
                      ({pspd_q, pdpx_q} == {speed_q, duplex_q} && !force_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        state_d = (idle_en && poll_zero) ? PHY_REQ : IDLE;
            PHY_REQ:     state_d = PHY_WAIT;
            PHY_WAIT:    state_d = i_phy_done ? DECODE : tmo_zero ? IDLE : PHY_WAIT;
            DECODE:      state_d = skip ? IDLE : MAC_RD_REQ;
            MAC_RD_REQ:  state_d = MAC_RD_WAIT;
            MAC_RD_WAIT: state_d = i_mac_done ? MAC_WR_REQ : tmo_zero ? IDLE : MAC_RD_WAIT;
            MAC_WR_REQ:  state_d = MAC_WR_WAIT;
            MAC_WR_WAIT: state_d = (i_mac_done || tmo_zero) ? IDLE : MAC_WR_WAIT;
            default:     state_d = IDLE;
        endcase
    end

    poll_timer #(.W(20), .RST_VAL(POLL_DIV)) u_poll (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .load_i     (idle_en && poll_zero),
        .load_val_i (POLL_DIV),
        .en_i       (idle_en),
        .zero_o     (poll_zero)
    );

    // Loaded while leaving each request state, so every wait starts afresh.
    poll_timer #(.W(16), .RST_VAL(TIMEOUT)) u_tmo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .load_i     (state_q inside {PHY_REQ, MAC_RD_REQ, MAC_WR_REQ}),
        .load_val_i (TIMEOUT),
        .en_i       (in_wait),
        .zero_o     (tmo_zero)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            pspd_q     <= SPD_10;
            pdpx_q     <= 1'b0;
            plink_q    <= 1'b0;
            link_q     <= 1'b0;
            speed_q    <= SPD_1000;
            duplex_q   <= 1'b1;
            force_q    <= 1'b0;
            phy_req_q  <= 1'b0;
            mac_req_q  <= 1'b0;
            mac_rdwn_q <= 1'b0;
            mux_q      <= 1'b0;
            wr_data_q  <= '0;
            update_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phy_req_q  <= (state_d == PHY_REQ);
            mac_req_q  <= state_d inside {MAC_RD_REQ, MAC_WR_REQ};
            mac_rdwn_q <= (state_d == MAC_RD_REQ);
            mux_q      <= state_d inside {MAC_RD_REQ, MAC_RD_WAIT, MAC_WR_REQ, MAC_WR_WAIT};
            update_q   <= wr_done;
            timeout_q  <= tmo_fire;
            force_q    <= i_force_update || (force_q && !wr_done);
            if (state_q == PHY_WAIT && i_phy_done) begin
                pspd_q  <= i_phy_rd_data[SPD_LSB +: 2];
                pdpx_q  <= i_phy_rd_data[DPX_BIT];
                plink_q <= i_phy_rd_data[LINK_BIT];
            end
            if (state_q == DECODE) link_q <= plink_q;
            if (state_q == MAC_RD_WAIT && i_mac_done)
                wr_data_q <= mac_cfg_word(i_mac_rd_data, pspd_q, pdpx_q,
                                          5'(MAC_PS_BIT), 5'(MAC_FES_BIT), 5'(MAC_DM_BIT));
            if (wr_done) begin
                speed_q  <= pspd_q;
                duplex_q <= pdpx_q;
            end
        end
    end

    assign o_phy_addr    = PHY_ADDR;
    assign o_phy_reg     = PHY_REG;
    assign o_phy_wr_data = '0;
    assign o_phy_rdwn    = phy_req_q;
    assign o_phy_request = phy_req_q;
    assign o_mac_addr    = MAC_CFG_ADDR;
    assign o_mac_wr_data = wr_data_q;
    assign o_mac_rdwn    = mac_rdwn_q;
    assign o_mac_request = mac_req_q;
    assign o_mux         = mux_q;
    assign o_link_up     = link_q;
    assign o_speed       = speed_q;
    assign o_duplex      = duplex_q;
    assign o_update      = update_q;
    assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_phy_link_poller.sv
// tb_phy_link_poller: directed checks of polling, MAC read-modify-write,
// link gating, timeout recovery, force update and async reset.
module tb_phy_link_poller;

    localparam logic [19:0] PD = 20'd8;
    localparam logic [15:0] TO = 16'd20;

    logic        i_clk = 1'b0, i_rst_n = 1'b0, i_enable = 1'b1, i_force_update = 1'b0;
    logic        i_phy_done = 1'b0, i_mac_done = 1'b0;
    logic [31:0] i_phy_rd_data = '0, i_mac_rd_data = '0;
    logic [4:0]  o_phy_addr, o_phy_reg;
    logic [31:0] o_phy_wr_data, o_mac_wr_data;
    logic [13:0] o_mac_addr;
    logic        o_phy_rdwn, o_phy_request, o_mac_rdwn, o_mac_request;
    logic        o_mux, o_link_up, o_duplex, o_update, o_timeout;
    logic [1:0]  o_speed;
    int          total = 0, bad = 0;

    phy_link_poller #(.POLL_DIV(PD), .PHY_ADDR(5'h03), .TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_force_update(i_force_update),
        .o_phy_addr(o_phy_addr), .o_phy_reg(o_phy_reg), .o_phy_wr_data(o_phy_wr_data),
        .o_phy_rdwn(o_phy_rdwn), .o_phy_request(o_phy_request), .i_phy_done(i_phy_done),
        .i_phy_rd_data(i_phy_rd_data), .o_mac_addr(o_mac_addr), .o_mac_wr_data(o_mac_wr_data),
        .o_mac_rdwn(o_mac_rdwn), .o_mac_request(o_mac_request), .i_mac_done(i_mac_done),
        .i_mac_rd_data(i_mac_rd_data), .o_mux(o_mux), .o_link_up(o_link_up), .o_speed(o_speed),
        .o_duplex(o_duplex), .o_update(o_update), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_phy_req(output int n);
        n = 0;
        while (o_phy_request !== 1'b1 && n < 100) begin @(negedge i_clk); n++; end
    endtask

    task automatic wait_mac_req(output int n);
        n = 0;
        while (o_mac_request !== 1'b1 && n < 100) begin @(negedge i_clk); n++; end
    endtask

    task automatic phy_resp(input logic [31:0] d);
        @(negedge i_clk);
        i_phy_done = 1'b1; i_phy_rd_data = d;
        @(negedge i_clk);
        i_phy_done = 1'b0; i_phy_rd_data = '0;
    endtask

    task automatic mac_resp(input logic [31:0] d);
        @(negedge i_clk);
        i_mac_done = 1'b1; i_mac_rd_data = d;
        @(negedge i_clk);
        i_mac_done = 1'b0; i_mac_rd_data = '0;
    endtask

    task automatic watch_quiet(input string t, input int cyc);
        logic seen = 1'b0;
        for (int i = 0; i < cyc; i++) begin
            @(negedge i_clk);
            seen = seen | o_mac_request | o_mux;
        end
        chk({t, " no mac access"}, seen, 1'b0);
    endtask

    task automatic rmw(input string t, input logic [31:0] pd, input logic [31:0] rd,
                       input logic [31:0] ew, input logic [1:0] es, input logic ed);
        int n;
        wait_phy_req(n);
        chk({t, " phy req seen"}, n < 100, 1'b1);
        chk({t, " phy rdwn"}, o_phy_rdwn, 1'b1);
        phy_resp(pd);
        wait_mac_req(n);
        chk({t, " mac rd seen"}, n < 100, 1'b1);
        chk({t, " mac rd rdwn"}, o_mac_rdwn, 1'b1);
        chk({t, " mux during rd"}, o_mux, 1'b1);
        mac_resp(rd);
        wait_mac_req(n);
        chk({t, " mac wr rdwn"}, o_mac_rdwn, 1'b0);
        chk({t, " mac wr data"}, o_mac_wr_data, ew);
        chk({t, " mux during wr"}, o_mux, 1'b1);
        mac_resp(32'h0);
        chk({t, " update pulse"}, o_update, 1'b1);
        chk({t, " speed"}, o_speed, es);
        chk({t, " duplex"}, o_duplex, ed);
        chk({t, " mux released"}, o_mux, 1'b0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge i_clk);
        chk("rst phy_addr", o_phy_addr, 5'h03);
        chk("rst phy_reg", o_phy_reg, 5'h11);
        chk("rst mac_addr", o_mac_addr, 14'h0);
        chk("rst phy_wr_data", o_phy_wr_data, 32'h0);
        chk("rst speed", o_speed, 2'b10);
        chk("rst duplex", o_duplex, 1'b1);
        chk("rst link", o_link_up, 1'b0);
        chk("rst mux", o_mux, 1'b0);
        chk("rst phy_request", o_phy_request, 1'b0);
        i_rst_n = 1'b1;
        wait_phy_req(n);
        chk("first poll latency", n, 9);

        rmw("1g half", 32'h0000_8400, 32'h1234_C8AC, 32'h1234_00AC, 2'b10, 1'b0);
        chk("link after 1g", o_link_up, 1'b1);

        wait_phy_req(n);
        chk("unchanged phy req", n < 100, 1'b1);
        phy_resp(32'h0000_8400);
        watch_quiet("unchanged", 8);

        rmw("100m full", 32'h0000_6400, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 1'b1);

        wait_phy_req(n);
        phy_resp(32'h0000_6000);
        @(negedge i_clk);
        chk("link down decoded", o_link_up, 1'b0);
        watch_quiet("link down", 6);
        chk("link down keeps speed", o_speed, 2'b01);

        wait_phy_req(n);
        phy_resp(32'h0000_C400);
        @(negedge i_clk);
        chk("rsvd speed link", o_link_up, 1'b1);
        watch_quiet("rsvd speed", 6);
        chk("rsvd keeps speed", o_speed, 2'b01);
        chk("rsvd keeps duplex", o_duplex, 1'b1);

        wait_phy_req(n);
        phy_resp(32'h0000_8400);
        wait_mac_req(n);
        chk("tmo mac rd seen", o_mac_rdwn, 1'b1);
        n = 0;
        while (o_timeout !== 1'b1 && n < 100) begin @(negedge i_clk); n++; end
        chk("timeout latency", n, TO + 2);
        chk("timeout mux", o_mux, 1'b0);
        chk("timeout keeps speed", o_speed, 2'b01);

        wait_phy_req(n);
        phy_resp(32'h0000_8400);
        wait_mac_req(n);
        repeat (TO) @(negedge i_clk);
        mac_resp(32'h0000_4800);
        chk("done beats timeout", o_timeout, 1'b0);
        chk("retry wr req", o_mac_request, 1'b1);
        chk("retry wr rdwn", o_mac_rdwn, 1'b0);
        chk("retry wr data", o_mac_wr_data, 32'h0000_0000);
        mac_resp(32'h0);
        chk("retry update", o_update, 1'b1);
        chk("retry speed", o_speed, 2'b10);
        chk("retry duplex", o_duplex, 1'b0);

        i_force_update = 1'b1;
        @(negedge i_clk);
        i_force_update = 1'b0;
        rmw("force", 32'h0000_8400, 32'hAAAA_AAAA, 32'hAAAA_22AA, 2'b10, 1'b0);
        wait_phy_req(n);
        phy_resp(32'h0000_8400);
        watch_quiet("force once", 8);

        wait_phy_req(n);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        chk("mid rst link", o_link_up, 1'b0);
        chk("mid rst speed", o_speed, 2'b10);
        chk("mid rst duplex", o_duplex, 1'b1);
        chk("mid rst wr_data", o_mac_wr_data, 32'h0);
        chk("mid rst mux", o_mux, 1'b0);
        chk("mid rst phy_request", o_phy_request, 1'b0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        wait_phy_req(n);
        chk("post rst poll latency", n, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phy_link_poller.md
Name: phy_link_poller

Overview:
- Parametrised successor to the fixed-address PHY speed poller in the gmac speed-control path.
- Periodically reads a configurable PHY status register through the shared MDIO request port and decodes link, speed (10/100/1000) and duplex.
- When the decoded mode differs from the mode applied to the MAC, performs a read-modify-write of the MAC configuration register (speed, fast-ethernet, duplex bits) while owning the MAC register bus mux.
- Adds a poll-interval timer, done-timeout recovery, link gating, a force-update input and status outputs.

Parameters:
- POLL_DIV, 20'd125000: cycles from end of one poll to start of the next (min 1).
- PHY_ADDR, 5'h00: MDIO PHY address.
- PHY_REG, 5'h11: PHY status register address.
- SPD_LSB, 14: bit position of 2-bit speed field in PHY data (00=10M, 01=100M, 10=1G, 11=reserved).
- DPX_BIT, 13: PHY full-duplex bit.
- LINK_BIT, 10: PHY link-up bit.
- MAC_CFG_ADDR, 14'h0000: MAC config register address.
- MAC_PS_BIT, 15: MAC port-select bit (1 = 10/100).
- MAC_FES_BIT, 14: MAC 100M-select bit.
- MAC_DM_BIT, 11: MAC duplex bit.
- TIMEOUT, 16'd4096: max cycles waiting for any done.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_enable  in  1  polling enable
- i_force_update  in  1  pulse: next successful poll rewrites the MAC even if unchanged
- o_phy_addr  out  5  PHY address
- o_phy_reg  out  5  PHY register address
- o_phy_wr_data  out  32  constant 0
- o_phy_rdwn  out  1  1=read
- o_phy_request  out  1  single-cycle request
- i_phy_done  in  1  single-cycle completion
- i_phy_rd_data  in  32  PHY read data, valid with done
- o_mac_addr  out  14  MAC register address
- o_mac_wr_data  out  32  MAC write data
- o_mac_rdwn  out  1  1=read
- o_mac_request  out  1  single-cycle request
- i_mac_done  in  1  single-cycle completion
- i_mac_rd_data  in  32  MAC read data, valid with done
- o_mux  out  1  1 = this block owns the MAC register bus
- o_link_up  out  1  last decoded link
- o_speed  out  2  speed applied to the MAC
- o_duplex  out  1  duplex applied to the MAC
- o_update  out  1  pulse: MAC write completed
- o_timeout  out  1  pulse: transaction aborted on timeout

Behaviour:
- Reset values:
  - All request/rdwn/mux/pulse outputs 0; o_mac_wr_data 0.
  - o_phy_addr = PHY_ADDR, o_phy_reg = PHY_REG, o_mac_addr = MAC_CFG_ADDR (constant after reset).
  - o_link_up 0; applied shadow o_speed 2'b10, o_duplex 1; interval counter = POLL_DIV; force flag 0.
- All outputs are registered.
- FSM states: IDLE, PHY_REQ, PHY_WAIT, DECODE, MAC_RD_REQ, MAC_RD_WAIT, MAC_WR_REQ, MAC_WR_WAIT.
- IDLE:
  - Counter decrements only while i_enable=1.
  - At 0 and i_enable=1: go to PHY_REQ and reload the counter.
  - i_enable=0 freezes the counter. An in-flight transaction always completes or times out.
- PHY_REQ: issue a one-cycle o_phy_request with rdwn=1, then go to PHY_WAIT.
- PHY_WAIT: on i_phy_done, capture data and go to DECODE. Done pulses in any other state are ignored.
- DECODE (1 cycle):
  - o_link_up <= LINK bit.
  - Go to IDLE if link=0, or speed=11 (reserved), or ({spd,dpx} == shadow and force flag=0).
  - Otherwise go to MAC_RD_REQ and set o_mux=1 in the same edge.
- MAC_RD_REQ: issue a read request, then MAC_RD_WAIT; on i_mac_done, capture read data.
- MAC_WR_REQ: o_mac_wr_data = captured data with:
  - PS = ~spd[1]
  - FES = (spd==01)
  - DM = dpx
  - all other bits preserved
  - Issue request with rdwn=0, then MAC_WR_WAIT.
- MAC_WR_WAIT: on i_mac_done:
  - shadow <= {spd,dpx}
  - pulse o_update
  - clear force flag
  - o_mux <= 0
  - go to IDLE
- o_mux stays 1 continuously from DECODE exit through the end of MAC_WR_WAIT. It is 0 at all other times.
- Timeout: a shared wait counter is cleared on entry to each *_WAIT state. On reaching TIMEOUT without done:
  - pulse o_timeout, o_mux <= 0, go to IDLE
  - shadow and force flag unchanged, so the next poll retries
- Simultaneous i_force_update with the clear on write-done: set wins.
- A done arriving in the same cycle the timeout fires: done wins.
- Reset mid-operation returns to IDLE immediately with reset values. No partial MAC write is reissued.

Decomposition:
- Package gmac_poll_pkg holds:
  - state enum
  - speed encodings SPD_10/SPD_100/SPD_1000/SPD_RSVD
  - helper function computing the modified MAC word from (rd_data, spd, dpx)
- One sub-module is natural: poll_timer (loadable down-counter with enable and zero flag), instanced for both the poll interval and the wait timeout.

Test Plan:
- POLL_DIV=8; PHY returns 0x0000_8400 (1G, half, link) → after ~9 cycles, MAC read then write of rd_data with DM bit=0 and PS=0; o_update pulses; o_duplex=0.
- Next poll returns the identical value → PHY read only, no MAC request, o_mux stays 0.
- PHY returns 0x0000_6400 (100M, full); MAC read returns 0xFFFF_FFFF → write data 0xFFFF_FFFF with PS=1, FES=1, DM=1 (bits preserved); o_speed=01.
- PHY returns link=0 or speed=11 → o_link_up / shadow behave per DECODE; no MAC access.
- Hold i_mac_done low for TIMEOUT cycles in MAC_RD_WAIT → o_timeout pulse, o_mux=0; next poll retries and completes.
- Pulse i_force_update with an unchanged PHY value → MAC RMW occurs once; assert i_rst_n low during PHY_WAIT → all outputs return to reset values.
